// File: rtl/csr_access_unit_if.sv
// Interface bundle for csr_access_unit: request, CSR-file and writeback/trap buses.
interface csr_access_unit_if;
    logic        requestValid;
    logic        requestReady;
    logic [2:0]  funct3;
    logic [11:0] csrAddress;
    logic [4:0]  rs1Index;
    logic [31:0] rs1Value;
    logic [4:0]  rdIndex;
    logic        flush;
    logic [2:0]  readCSR;
    logic [31:0] csrReadData;
    logic [2:0]  destinationCSR;
    logic [31:0] csrWriteData;
    logic        csrDestinationEnable;
    logic        resultValid;
    logic [31:0] resultData;
    logic [4:0]  resultRd;
    logic        illegalValid;
    logic [3:0]  mcause;

    modport slave (
        input  requestValid, funct3, csrAddress, rs1Index, rs1Value, rdIndex,
               flush, csrReadData,
        output requestReady, readCSR, destinationCSR, csrWriteData,
               csrDestinationEnable, resultValid, resultData, resultRd,
               illegalValid, mcause
    );

    modport master (
        output requestValid, funct3, csrAddress, rs1Index, rs1Value, rdIndex,
               flush, csrReadData,
        input  requestReady, readCSR, destinationCSR, csrWriteData,
               csrDestinationEnable, resultValid, resultData, resultRd,
               illegalValid, mcause
    );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr sequencer: legal op = accept, READ, WRITE (3 cycles); illegal = accept, FAULT (2 cycles).
// Ready only in IDLE without flush, so a new request waits until the previous one retires.
module csr_access_unit (
    input  logic            clock,
    input  logic            reset,
    csr_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FAULT} state_t;

    localparam logic [2:0] IDX_MSTATUS  = 3'd0;
    localparam logic [2:0] IDX_MISA     = 3'd1;
    localparam logic [2:0] IDX_MTVEC    = 3'd2;
    localparam logic [2:0] IDX_MEPC     = 3'd3;
    localparam logic [2:0] IDX_MCAUSE   = 3'd4;
    localparam logic [2:0] IDX_MTVAL    = 3'd5;
    localparam logic [2:0] IDX_MCYCLE   = 3'd6;
    localparam logic [2:0] IDX_MINSTRET = 3'd7;

    state_t      state, nextState;
    logic [2:0]  funct3Reg;
    logic [2:0]  indexReg;
    logic [4:0]  rs1IndexReg;
    logic [31:0] rs1ValueReg;
    logic [4:0]  rdReg;
    logic [31:0] oldValue;
    logic [31:0] newValue;
    logic        writeEnableReg;

    logic [2:0]  mappedIndex;
    logic        addressLegal;
    logic        requestLegal;
    logic        accept;
    logic [31:0] source;
    logic [31:0] computedNew;
    logic        writeSuppress;
    logic        readyInt, writeStrobe, resultStrobe, illegalStrobe;

    always_comb begin
        mappedIndex  = IDX_MSTATUS;
        addressLegal = 1'b1;
        case (bus.csrAddress)
            12'h300: mappedIndex = IDX_MSTATUS;
            12'h301: mappedIndex = IDX_MISA;
            12'h305: mappedIndex = IDX_MTVEC;
            12'h341: mappedIndex = IDX_MEPC;
            12'h342: mappedIndex = IDX_MCAUSE;
            12'h343: mappedIndex = IDX_MTVAL;
            12'hB00: mappedIndex = IDX_MCYCLE;
            12'hB02: mappedIndex = IDX_MINSTRET;
            default: addressLegal = 1'b0;
        endcase
    end

    // funct3 x00 is not a CSR op (000 is ECALL/EBREAK space, 100 is reserved).
    assign requestLegal = addressLegal && (bus.funct3[1:0] != 2'b00);

    assign source = funct3Reg[2] ? {27'b0, rs1IndexReg} : rs1ValueReg;

    always_comb begin
        case (funct3Reg[1:0])
            2'b01:   computedNew = source;
            2'b10:   computedNew = bus.csrReadData | source;
            2'b11:   computedNew = bus.csrReadData & ~source;
            default: computedNew = bus.csrReadData;
        endcase
    end

    // Set/clear with a zero source has no side effects; MISA silently ignores writes.
    assign writeSuppress = ((funct3Reg[1:0] != 2'b01) && (rs1IndexReg == 5'd0))
                         || (indexReg == IDX_MISA);

    always_comb begin
        nextState     = state;
        readyInt      = 1'b0;
        accept        = 1'b0;
        writeStrobe   = 1'b0;
        resultStrobe  = 1'b0;
        illegalStrobe = 1'b0;
        case (state)
            IDLE: begin
                readyInt = !bus.flush && !reset;
                if (bus.requestValid && !bus.flush) begin
                    accept    = 1'b1;
                    nextState = requestLegal ? READ : FAULT;
                end
            end
            READ:  nextState = WRITE;
            WRITE: begin
                writeStrobe  = writeEnableReg;
                resultStrobe = 1'b1;
                nextState    = IDLE;
            end
            FAULT: begin
                illegalStrobe = 1'b1;
                nextState     = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (bus.flush || reset) begin
            nextState     = IDLE;
            accept        = 1'b0;
            writeStrobe   = 1'b0;
            resultStrobe  = 1'b0;
            illegalStrobe = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            funct3Reg      <= 3'd0;
            indexReg       <= IDX_MSTATUS;
            rs1IndexReg    <= 5'd0;
            rs1ValueReg    <= 32'd0;
            rdReg          <= 5'd0;
            oldValue       <= 32'd0;
            newValue       <= 32'd0;
            writeEnableReg <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                funct3Reg   <= bus.funct3;
                indexReg    <= mappedIndex;
                rs1IndexReg <= bus.rs1Index;
                rs1ValueReg <= bus.rs1Value;
                rdReg       <= bus.rdIndex;
            end
            if (state == READ) begin
                oldValue       <= bus.csrReadData;
                newValue       <= computedNew;
                writeEnableReg <= !writeSuppress;
            end
        end
    end

    assign bus.requestReady         = readyInt;
    assign bus.readCSR              = indexReg;
    assign bus.destinationCSR       = indexReg;
    assign bus.csrWriteData         = newValue;
    assign bus.csrDestinationEnable = writeStrobe;
    assign bus.resultValid          = resultStrobe;
    assign bus.resultData           = oldValue;
    assign bus.resultRd             = rdReg;
    assign bus.illegalValid         = illegalStrobe;
    assign bus.mcause               = illegalStrobe ? 4'h2 : 4'h0;
endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small behavioural CSR file behind it.
module tb_csr_access_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectorCount = 0;
    int   miscompares = 0;

    csr_access_unit_if bus ();

    csr_access_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // CSR file: combinational read, write on strobe, known contents out of reset.
    logic [31:0] csrFile [8];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) csrFile[i] <= 32'd0;
            csrFile[0] <= 32'h0000_1800;
            csrFile[1] <= 32'h4000_0100;
            csrFile[3] <= 32'h0000_00FF;
        end else if (bus.csrDestinationEnable) begin
            csrFile[bus.destinationCSR] <= bus.csrWriteData;
        end
    end
    assign bus.csrReadData = csrFile[bus.readCSR];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic present(input logic [2:0] f3, input logic [11:0] addr,
                           input logic [4:0] rs1i, input logic [31:0] rs1v, input logic [4:0] rd);
        @(negedge clock);
        bus.requestValid = 1'b1;
        bus.funct3       = f3;
        bus.csrAddress   = addr;
        bus.rs1Index     = rs1i;
        bus.rs1Value     = rs1v;
        bus.rdIndex      = rd;
        @(posedge clock);
        #1 bus.requestValid = 1'b0;
    endtask

    task automatic run_legal(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                             input logic [4:0] rs1i, input logic [31:0] rs1v, input logic [4:0] rd,
                             input logic [2:0] expIdx, input logic expWe,
                             input logic [31:0] expNew, input logic [31:0] expOld);
        present(f3, addr, rs1i, rs1v, rd);
        @(negedge clock);
        check({tag, ".read.idx"},    {29'd0, bus.readCSR}, {29'd0, expIdx});
        check({tag, ".read.ready"},  {31'd0, bus.requestReady}, 32'd0);
        check({tag, ".read.we"},     {31'd0, bus.csrDestinationEnable}, 32'd0);
        check({tag, ".read.rv"},     {31'd0, bus.resultValid}, 32'd0);
        @(negedge clock);
        check({tag, ".wr.we"},       {31'd0, bus.csrDestinationEnable}, {31'd0, expWe});
        if (expWe) begin
            check({tag, ".wr.dest"}, {29'd0, bus.destinationCSR}, {29'd0, expIdx});
            check({tag, ".wr.data"}, bus.csrWriteData, expNew);
        end
        check({tag, ".wr.rv"},       {31'd0, bus.resultValid}, 32'd1);
        check({tag, ".wr.old"},      bus.resultData, expOld);
        check({tag, ".wr.rd"},       {27'd0, bus.resultRd}, {27'd0, rd});
        check({tag, ".wr.ill"},      {31'd0, bus.illegalValid}, 32'd0);
        @(negedge clock);
        check({tag, ".done.ready"},  {31'd0, bus.requestReady}, 32'd1);
        check({tag, ".done.rv"},     {31'd0, bus.resultValid}, 32'd0);
        check({tag, ".done.we"},     {31'd0, bus.csrDestinationEnable}, 32'd0);
    endtask

    task automatic run_illegal(input string tag, input logic [2:0] f3, input logic [11:0] addr);
        present(f3, addr, 5'd1, 32'h1234_5678, 5'd4);
        @(negedge clock);
        check({tag, ".ill"},        {31'd0, bus.illegalValid}, 32'd1);
        check({tag, ".mcause"},     {28'd0, bus.mcause}, 32'd2);
        check({tag, ".we"},         {31'd0, bus.csrDestinationEnable}, 32'd0);
        check({tag, ".rv"},         {31'd0, bus.resultValid}, 32'd0);
        @(negedge clock);
        check({tag, ".next.ill"},   {31'd0, bus.illegalValid}, 32'd0);
        check({tag, ".next.mc"},    {28'd0, bus.mcause}, 32'd0);
        check({tag, ".next.ready"}, {31'd0, bus.requestReady}, 32'd1);
        check({tag, ".next.rv"},    {31'd0, bus.resultValid}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".ready"}, {31'd0, bus.requestReady}, 32'd1);
        check({tag, ".we"},    {31'd0, bus.csrDestinationEnable}, 32'd0);
        check({tag, ".rv"},    {31'd0, bus.resultValid}, 32'd0);
        check({tag, ".ill"},   {31'd0, bus.illegalValid}, 32'd0);
        check({tag, ".rdata"}, bus.resultData, 32'd0);
        check({tag, ".wdata"}, bus.csrWriteData, 32'd0);
        check({tag, ".rd"},    {27'd0, bus.resultRd}, 32'd0);
        check({tag, ".mc"},    {28'd0, bus.mcause}, 32'd0);
        check({tag, ".ridx"},  {29'd0, bus.readCSR}, 32'd0);
        check({tag, ".widx"},  {29'd0, bus.destinationCSR}, 32'd0);
    endtask

    initial begin
        bus.requestValid = 1'b0;
        bus.funct3       = 3'd0;
        bus.csrAddress   = 12'd0;
        bus.rs1Index     = 5'd0;
        bus.rs1Value     = 32'd0;
        bus.rdIndex      = 5'd0;
        bus.flush        = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_values("reset");

        run_legal("csrrw_mtvec",   3'b001, 12'h305, 5'd6, 32'h0000_0100, 5'd5, 3'd2, 1'b1, 32'h0000_0100, 32'h0);
        run_legal("readback_mtvec",3'b010, 12'h305, 5'd0, 32'hFFFF_FFFF, 5'd8, 3'd2, 1'b0, 32'h0, 32'h0000_0100);
        run_legal("csrrs_x0",      3'b010, 12'h300, 5'd0, 32'h0000_0008, 5'd1, 3'd0, 1'b0, 32'h0, 32'h0000_1800);
        run_legal("csrrs_mstatus", 3'b010, 12'h300, 5'd2, 32'h0000_0008, 5'd1, 3'd0, 1'b1, 32'h0000_1808, 32'h0000_1800);
        run_legal("csrrci_mepc",   3'b111, 12'h341, 5'd3, 32'hFFFF_FFFF, 5'd3, 3'd3, 1'b1, 32'h0000_00FC, 32'h0000_00FF);
        run_legal("csrrsi_mtval",  3'b110, 12'h343, 5'd21, 32'hFFFF_FFFF, 5'd2, 3'd5, 1'b1, 32'h0000_0015, 32'h0);
        run_legal("csrrw_rd0",     3'b001, 12'hB02, 5'd9, 32'hCAFE_0001, 5'd0, 3'd7, 1'b1, 32'hCAFE_0001, 32'h0);
        run_legal("csrrw_misa",    3'b001, 12'h301, 5'd4, 32'h0000_0000, 5'd6, 3'd1, 1'b0, 32'h0, 32'h4000_0100);

        run_illegal("bad_addr", 3'b001, 12'h7C0);
        run_illegal("f3_100",   3'b100, 12'h300);
        run_illegal("f3_000",   3'b000, 12'h305);

        // Request presented together with flush in IDLE must be ignored.
        @(negedge clock);
        bus.flush = 1'b1;
        present(3'b001, 12'h305, 5'd1, 32'h0000_BEEF, 5'd9);
        bus.flush = 1'b0;
        @(negedge clock);
        check("flush_idle.ready", {31'd0, bus.requestReady}, 32'd1);
        @(negedge clock);
        check("flush_idle.rv",    {31'd0, bus.resultValid}, 32'd0);
        check("flush_idle.we",    {31'd0, bus.csrDestinationEnable}, 32'd0);

        // Flush while in READ kills the op.
        present(3'b001, 12'h305, 5'd1, 32'h0000_DEAD, 5'd9);
        bus.flush = 1'b1;
        @(negedge clock);
        check("flush_read.we", {31'd0, bus.csrDestinationEnable}, 32'd0);
        check("flush_read.rv", {31'd0, bus.resultValid}, 32'd0);
        @(posedge clock);
        #1 bus.flush = 1'b0;
        @(negedge clock);
        check("flush_read.ready", {31'd0, bus.requestReady}, 32'd1);
        check("flush_read.we2",   {31'd0, bus.csrDestinationEnable}, 32'd0);
        check("flush_read.rv2",   {31'd0, bus.resultValid}, 32'd0);
        run_legal("after_flush_mtvec", 3'b010, 12'h305, 5'd0, 32'h0, 5'd10, 3'd2, 1'b0, 32'h0, 32'h0000_0100);

        // Reset during WRITE: no strobe in the reset cycle, reset values afterwards.
        present(3'b001, 12'h343, 5'd7, 32'h0000_ABCD, 5'd7);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("reset_wr.we", {31'd0, bus.csrDestinationEnable}, 32'd0);
        check("reset_wr.rv", {31'd0, bus.resultValid}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_values("reset_wr.after");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Execute-stage sequencer that carries out Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) against the machine CSR file. It accepts one decoded CSR instruction per handshake, maps the 12-bit CSR address to the CSR file index, reads the old value, computes and commits the new value, and returns the old value for register writeback. It drives the CSR file's read-index and write ports and reports illegal CSR instructions to trap control.

## Interface
Parameters: none.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, all state cleared on the rising edge.
- requestValid  in  1  decoded CSR instruction present.
- requestReady  out  1  unit can accept; high only in IDLE.
- funct3  in  3  Zicsr funct3.
- csrAddress  in  12  instruction CSR address.
- rs1Index  in  5  rs1 field; doubles as zimm for immediate forms.
- rs1Value  in  32  rs1 register value.
- rdIndex  in  5  destination register.
- flush  in  1  pipeline kill, same meaning as controlReset.
- readCSR  out  destinationCSR_  CSR file read index.
- csrReadData  in  32  CSR file read data (combinational from readCSR).
- destinationCSR  out  destinationCSR_  CSR file write index.
- csrWriteData  out  32  CSR file write data.
- csrDestinationEnable  out  1  CSR file write strobe.
- resultValid  out  1  one-cycle writeback pulse.
- resultData  out  32  old CSR value.
- resultRd  out  5  writeback register.
- illegalValid  out  1  one-cycle illegal-instruction pulse.
- mcause  out  4  4'h2 whenever illegalValid, else 0.

## Operation
- States: IDLE, READ, WRITE, FAULT.
- IDLE: requestReady=1. On requestValid, register funct3, mapped index, rs1Index, rs1Value, rdIndex; go READ if legal, FAULT if illegal.
- Address map: 0x300→MSTATUS, 0x301→MISA, 0x305→MTVEC, 0x341→MEPC, 0x342→MCAUSE, 0x343→MTVAL, 0xB00→MCYCLE, 0xB02→MINSTRET. Any other address is illegal.
- Illegal also when funct3 is 3'b000 or 3'b100.
- READ: readCSR = registered index; capture csrReadData into oldValue; compute newValue; go WRITE.
- Source: funct3[2] ? {27'b0, rs1Index} : rs1Value.
- newValue: RW (funct3[1:0]=01) = source; RS (10) = oldValue | source; RC (11) = oldValue & ~source.
- Write suppression: RS/RC with rs1Index==0 never write. RW always writes, including when rdIndex==0.
- MISA is WARL read-only here: writes to MISA are suppressed, no trap.
- WRITE: csrDestinationEnable=1 (unless suppressed), destinationCSR=index, csrWriteData=newValue; resultValid=1, resultData=oldValue, resultRd=rdIndex; go IDLE.
- FAULT: illegalValid=1, mcause=4'h2; no write, no result; go IDLE.
- flush in any state: next state IDLE. csrDestinationEnable, resultValid, and illegalValid are forced 0 in that same cycle. A request presented with flush in IDLE is not accepted.
- When not in READ, readCSR holds the last registered index; it is don't-care to the consumer.

## Timing
- Reset values: state IDLE; requestReady=1 from the first post-reset cycle. csrDestinationEnable, resultValid, illegalValid=0; resultData, csrWriteData=0; resultRd=0; mcause=0; readCSR and destinationCSR = index 0.
- Legal accept at edge T: READ in cycle T+1; write strobe and result in cycle T+2 (single cycle each); IDLE and ready again in T+3. Throughput is one instruction per 3 cycles.
- Illegal accept at edge T: illegalValid in T+1; ready again in T+2.
- MCYCLE read returns the value present during the READ cycle. A write to MCYCLE/MINSTRET in WRITE takes priority over the CSR file's increment (CSR-file rule).
- reset mid-operation: aborts immediately; no strobe is issued on or after the reset cycle.

## Test plan
- After reset, MTVEC=0. CSRRW x5, mtvec, rs1Value=0x00000100 → T+2: write to MTVEC with 0x100; resultData=0; resultRd=5; next read of mtvec returns 0x100.
- MSTATUS=0x1800. CSRRS x1, mstatus, rs1=x2 with value 0x8 → writes 0x1808; resultData=0x1800. Same instruction with rs1=x0 → no strobe, resultData=0x1800.
- CSRRCI x3, mepc, zimm=0x3 with MEPC=0xFF → writes 0xFC; resultData=0xFF.
- CSRRW to address 0x7C0 → illegalValid in T+1 with mcause=2; no strobe or result. funct3=3'b100 → same response.
- CSRRW misa, rs1Value=0 → no write; resultData=0x40000100.
- flush asserted during READ → no strobe, no result; requestReady=1 the next cycle. reset asserted during WRITE → all outputs at reset values the following cycle.
